// File: rtl/spi_cfg_pkg.sv
// rtl/spi_cfg_pkg.sv - frame geometry, register map and sequencer state type
package spi_cfg_pkg;

   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 8;

   localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
   localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
   localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
   localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
   localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } seq_state_t;

   // Wire order on the link: write flag, address, data, MSB first.
   function automatic logic [FRAME_W-1:0] pack_frame(input logic wr,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
      return {wr, addr, data};
   endfunction

endpackage

// File: rtl/spi_cfg_sequencer_if.sv
// rtl/spi_cfg_sequencer_if.sv - requester handshakes and SPI pins of the config sequencer
interface spi_cfg_sequencer_if;
   import spi_cfg_pkg::*;

   logic              req0_valid;
   logic              req0_wr;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;

   logic              req1_valid;
   logic              req1_wr;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;

   logic              nCS;
   logic              SCLK;
   logic              COPI;

   // Sequencer side: takes requests, drives the SPI link.
   modport master (
      input  req0_valid, req0_wr, req0_addr, req0_data,
      input  req1_valid, req1_wr, req1_addr, req1_data,
      output req0_ready, req1_ready,
      output nCS, SCLK, COPI
   );

   // Requester / peripheral side.
   modport slave (
      output req0_valid, req0_wr, req0_addr, req0_data,
      output req1_valid, req1_wr, req1_addr, req1_data,
      input  req0_ready, req1_ready,
      input  nCS, SCLK, COPI
   );

endinterface

// File: rtl/spi_cfg_sequencer_rr_arbiter2.sv
// rtl/spi_cfg_sequencer_rr_arbiter2.sv - two-way round-robin grant, pointer moves on accept
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic       gnt_valid,
   output logic       gnt_id
);

   // Requester served most recently; reset to 1 so requester 0 wins the first tie.
   logic last_q;

   // Winner: a lone requester, or on a tie the one not served last.
   always_comb begin
      gnt_valid = |req;
      gnt_id    = 1'b0;
      if (req[0] && req[1]) begin
         gnt_id = ~last_q;
      end else if (req[1]) begin
         gnt_id = 1'b1;
      end
   end

   // Pointer only moves when the grant is actually taken, so withdrawn requests leave no trace.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else if (accept) begin
         last_q <= gnt_id;
      end
   end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// rtl/spi_cfg_sequencer.sv - arbitrates two register writers onto one mode-0 SPI link
module spi_cfg_sequencer
   import spi_cfg_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_IDLE  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   spi_cfg_sequencer_if.master  bus,
   output logic                 busy,
   output logic                 grant_id,
   output logic                 frame_done
);

   localparam int PH_W     = $clog2(CLK_DIV);
   localparam int WAIT_MAX = (CS_SETUP > CLK_DIV) ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                                  : ((CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE);
   localparam int WAIT_W   = $clog2(WAIT_MAX);

   generate
      if (CLK_DIV < 2) begin : g_bad_clk_div
         $error("spi_cfg_sequencer: CLK_DIV must be >= 2");
      end
      if (CS_SETUP < 1) begin : g_bad_cs_setup
         $error("spi_cfg_sequencer: CS_SETUP must be >= 1");
      end
      if (CS_IDLE < 4) begin : g_bad_cs_idle
         $error("spi_cfg_sequencer: CS_IDLE must be >= 4");
      end
   endgenerate

   seq_state_t          state_q, state_d;
   logic [PH_W-1:0]     ph_q, ph_d;
   logic [4:0]          bit_q, bit_d, bit_nxt;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [FRAME_W-1:0]  sreg_q, sreg_d;
   logic                ncs_q, ncs_d;
   logic                sclk_q, sclk_d;
   logic                gid_q, gid_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;

   logic                gnt_valid, gnt_id, accept;
   logic [FRAME_W-1:0]  frame_in;

   rr_arbiter2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       ({bus.req1_valid, bus.req0_valid}),
      .accept    (accept),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   // A frame is taken only from IDLE and never in a reset cycle.
   assign accept         = (state_q == ST_IDLE) && gnt_valid && !rst;
   assign bus.req0_ready = accept && !gnt_id;
   assign bus.req1_ready = accept && gnt_id;
   assign frame_in       = gnt_id ? pack_frame(bus.req1_wr, bus.req1_addr, bus.req1_data)
                                  : pack_frame(bus.req0_wr, bus.req0_addr, bus.req0_data);

   // COPI is the shift register MSB, so it moves only when the register shifts (low-phase start).
   assign bus.nCS  = ncs_q;
   assign bus.SCLK = sclk_q;
   assign bus.COPI = sreg_q[FRAME_W-1];
   assign busy       = busy_q;
   assign grant_id   = gid_q;
   assign frame_done = done_q;

   // Next-state and next-output decode; SCLK register doubles as the low/high half flag.
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      bit_d   = bit_q;
      bit_nxt = bit_q + 5'd1;
      wait_d  = wait_q;
      sreg_d  = sreg_q;
      ncs_d   = ncs_q;
      sclk_d  = sclk_q;
      gid_d   = gid_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SETUP;
               wait_d  = '0;
               sreg_d  = frame_in;
               gid_d   = gnt_id;
               ncs_d   = 1'b0;
            end
         end
         ST_SETUP: begin
            if (wait_q == WAIT_W'(CS_SETUP - 1)) begin
               state_d = ST_SHIFT;
               ph_d    = '0;
               bit_d   = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_SHIFT: begin
            if (ph_q == PH_W'(CLK_DIV - 1)) begin
               ph_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  bit_d  = bit_nxt;
                  if (bit_nxt == 5'd16) begin
                     state_d = ST_HOLD;
                     wait_d  = '0;
                  end else begin
                     sreg_d = {sreg_q[FRAME_W-2:0], 1'b0};
                  end
               end
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         ST_HOLD: begin
            if (wait_q == WAIT_W'(CLK_DIV - 1)) begin
               state_d = ST_GAP;
               wait_d  = '0;
               ncs_d   = 1'b1;
               done_d  = 1'b1;
               sreg_d  = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_GAP: begin
            if (wait_q == WAIT_W'(CS_IDLE - 1)) begin
               state_d = ST_IDLE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered SPI outputs; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ph_q    <= '0;
         bit_q   <= '0;
         wait_q  <= '0;
         sreg_q  <= '0;
         ncs_q   <= 1'b1;
         sclk_q  <= 1'b0;
         gid_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         wait_q  <= wait_d;
         sreg_q  <= sreg_d;
         ncs_q   <= ncs_d;
         sclk_q  <= sclk_d;
         gid_q   <= gid_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb/tb_spi_cfg_sequencer.sv - randomized model-checked bench for spi_cfg_sequencer
module tb_spi_cfg_sequencer;
   import spi_cfg_pkg::*;

   localparam int CLK_DIV  = 4;
   localparam int CS_SETUP = 2;
   localparam int CS_IDLE  = 4;
   localparam int SH_START = 1 + CS_SETUP;
   localparam int SH_END   = SH_START + 32 * CLK_DIV;
   localparam int GAP_D    = SH_END + CLK_DIV;
   localparam int PERIOD   = GAP_D + CS_IDLE;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy, grant_id, frame_done;

   spi_cfg_sequencer_if bus();

   spi_cfg_sequencer #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .busy       (busy),
      .grant_id   (grant_id),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;
   bit rand_pl = 1'b0;

   // Reference model: last accepted frame, its start cycle, owner and the tie pointer.
   int          m_t = -100000;
   logic [15:0] m_frm = '0;
   logic        m_gid = 1'b0;
   logic        m_last = 1'b1;

   // Observations from the pins, plus a behavioural register file standing in for the peripheral.
   int          acc_q[$];
   int          acc_cyc_q[$];
   int          rise_q[$];
   logic [15:0] rx_q[$];
   logic [7:0]  regs [0:127];
   logic [15:0] sh = '0;
   int          rises = 0, first_rise = 0, last_rise = 0;
   int          ncs_fall_cyc = 0, ncs_rise_cyc = 0, done_cyc = 0;
   int          done_cnt = 0, stray = 0, r0_hi = 0;
   logic        prev_ncs = 1'b1, prev_sclk = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Per-cycle comparison against the timing rules, then advance the model.
   task automatic model_step();
      int d;
      logic idle, win, v0, v1, e_r0, e_r1, cm;
      logic [7:0] ev, av;
      d    = cyc - m_t;
      idle = (d >= PERIOD);
      v0   = bus.req0_valid;
      v1   = bus.req1_valid;
      win  = (v0 && v1) ? !m_last : v1;
      e_r0 = idle && !rst && v0 && !win;
      e_r1 = idle && !rst && v1 && win;
      ev   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_gid, e_r0, e_r1};
      cm   = 1'b1;
      if (!idle) begin
         ev[4] = 1'b1;
         if (d < GAP_D) ev[7] = 1'b0;
         if (d == GAP_D) ev[3] = 1'b1;
         if (d < SH_START) begin
            ev[5] = m_frm[15];
         end else if (d < SH_END) begin
            ev[6] = ((d - SH_START) % (2 * CLK_DIV)) >= CLK_DIV;
            ev[5] = m_frm[15 - (d - SH_START) / (2 * CLK_DIV)];
         end else if (d < GAP_D) begin
            cm = 1'b0;
         end
      end
      av = {bus.nCS, bus.SCLK, bus.COPI, busy, frame_done, grant_id, bus.req0_ready, bus.req1_ready};
      if (!cm) begin
         ev[5] = 1'b0;
         av[5] = 1'b0;
      end
      if (chk_en)
         check($sformatf("cycle%0d {ncs,sclk,copi,busy,done,gid,rdy0,rdy1}", cyc), {24'd0, av}, {24'd0, ev});
      if (rst) begin
         m_t    = -100000;
         m_gid  = 1'b0;
         m_last = 1'b1;
      end else if (e_r0 || e_r1) begin
         m_t    = cyc;
         m_gid  = win;
         m_last = win;
         m_frm  = win ? {bus.req1_wr, bus.req1_addr, bus.req1_data}
                      : {bus.req0_wr, bus.req0_addr, bus.req0_data};
      end
   endtask

   // Pin monitor and peripheral stand-in: shift COPI on SCLK rises, commit writes when nCS rises.
   always @(negedge clk) begin
      if (chk_en) begin
         if (prev_ncs && !bus.nCS) begin
            ncs_fall_cyc = cyc;
            rises = 0;
         end
         if (!prev_sclk && bus.SCLK) begin
            if (bus.nCS) begin
               stray++;
            end else begin
               sh = {sh[14:0], bus.COPI};
               rises++;
               if (rises == 1) first_rise = cyc;
               last_rise = cyc;
            end
         end
         if (!prev_ncs && bus.nCS) begin
            ncs_rise_cyc = cyc;
            rise_q.push_back(rises);
            if (rises == 16) begin
               rx_q.push_back(sh);
               if (sh[15]) regs[sh[14:8]] = sh[7:0];
            end
         end
         if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.req0_ready) r0_hi++;
         if (bus.req0_valid && bus.req0_ready) begin
            acc_q.push_back(0);
            acc_cyc_q.push_back(cyc);
         end
         if (bus.req1_valid && bus.req1_ready) begin
            acc_q.push_back(1);
            acc_cyc_q.push_back(cyc);
         end
         prev_ncs  = bus.nCS;
         prev_sclk = bus.SCLK;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_pl) begin
         bus.req0_wr   = 1'($urandom);
         bus.req0_addr = 7'($urandom);
         bus.req0_data = 8'($urandom);
         bus.req1_wr   = 1'($urandom);
         bus.req1_addr = 7'($urandom);
         bus.req1_data = 8'($urandom);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input bit id, input bit wr, input logic [6:0] a, input logic [7:0] dt);
      int n;
      @(posedge clk);
      #1;
      if (id) begin
         bus.req1_wr = wr; bus.req1_addr = a; bus.req1_data = dt; bus.req1_valid = 1'b1;
      end else begin
         bus.req0_wr = wr; bus.req0_addr = a; bus.req0_data = dt; bus.req0_valid = 1'b1;
      end
      n = 0;
      @(negedge clk);
      while (!(id ? bus.req1_ready : bus.req0_ready) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("send_accepted", {31'd0, n < 400}, 32'd1);
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic hold_valid(input bit v0, input bit v1, input int count);
      int base, g;
      base = acc_q.size();
      rand_pl = 1'b1;
      bus.req0_valid = v0;
      bus.req1_valid = v1;
      g = 0;
      while (acc_q.size() < base + count && g < (count + 1) * PERIOD) begin
         tick();
         g++;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      rand_pl = 1'b0;
   endtask

   initial begin
      int t, base, nrx, nd, r0b;
      bus.req0_valid = 1'b0; bus.req0_wr = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
      bus.req1_valid = 1'b0; bus.req1_wr = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
      fork
         forever begin
            @(negedge clk);
            model_step();
         end
      join_none
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;

      @(negedge clk);
      check("rst_ncs", {31'd0, bus.nCS}, 32'd1);
      check("rst_sclk", {31'd0, bus.SCLK}, 32'd0);
      check("rst_copi", {31'd0, bus.COPI}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_gid", {31'd0, grant_id}, 32'd0);
      check("rst_done", {31'd0, frame_done}, 32'd0);

      // Single frame, fixed payload, with hand-computed timing.
      r0b = r0_hi;
      send(1'b0, 1'b1, REG_EN_PWM_7_0, 8'hA5);
      t = acc_cyc_q[$];
      wait_cycles(PERIOD);
      check("t1_frame", {16'd0, rx_q[$]}, 32'h82A5);
      check("t1_ncs_fall", ncs_fall_cyc - t, 32'd1);
      check("t1_first_rise", first_rise - t, 32'd7);
      check("t1_last_rise", last_rise - t, 32'd127);
      check("t1_rises", rise_q[$], 32'd16);
      check("t1_ncs_rise", ncs_rise_cyc - t, 32'd135);
      check("t1_done", done_cyc - t, 32'd135);
      check("t1_ready_cycles", r0_hi - r0b, 32'd1);

      // Both requesters continuously valid from reset.
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      base = acc_q.size();
      hold_valid(1'b1, 1'b1, 4);
      check("rr_count", acc_q.size() - base, 32'd4);
      if (acc_q.size() >= base + 4) begin
         for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), acc_q[base + i], i % 2);
         for (int i = 0; i < 3; i++)
            check($sformatf("rr_period%0d", i), acc_cyc_q[base + i + 1] - acc_cyc_q[base + i], 32'd139);
      end
      wait_cycles(PERIOD);
      check("no_stray_sclk", stray, 32'd0);

      // Only requester 1, three back-to-back frames.
      base = acc_q.size();
      hold_valid(1'b0, 1'b1, 3);
      wait_cycles(PERIOD);
      check("r1_count", acc_q.size() - base, 32'd3);
      if (acc_q.size() >= base + 3 && rise_q.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("r1_id%0d", i), acc_q[base + i], 32'd1);
            check($sformatf("r1_rises%0d", i), rise_q[rise_q.size() - 3 + i], 32'd16);
         end
      end

      // Reset 40 cycles into a frame.
      send(1'b0, 1'b1, REG_EN_OUT_15_8, 8'h3C);
      nd = done_cnt;
      nrx = rx_q.size();
      repeat (39) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_ncs", {31'd0, bus.nCS}, 32'd1);
      check("abort_sclk", {31'd0, bus.SCLK}, 32'd0);
      check("abort_copi", {31'd0, bus.COPI}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, frame_done}, 32'd0);
      wait_cycles(PERIOD);
      check("abort_no_done", done_cnt - nd, 32'd0);
      check("abort_no_rx", rx_q.size() - nrx, 32'd0);
      send(1'b1, 1'b1, REG_EN_PWM_15_8, 8'h5A);
      wait_cycles(PERIOD);
      check("after_abort_frame", {16'd0, rx_q[$]}, 32'h835A);

      // Peripheral register effects.
      send(1'b0, 1'b1, REG_PWM_DUTY, 8'h80);
      wait_cycles(PERIOD);
      check("pwm_duty", {24'd0, regs[4]}, 32'h80);
      send(1'b1, 1'b1, REG_EN_OUT_7_0, 8'hFF);
      wait_cycles(PERIOD);
      check("en_out_lo", {24'd0, regs[0]}, 32'hFF);
      send(1'b0, 1'b0, REG_EN_OUT_7_0, 8'h00);
      wait_cycles(PERIOD);
      check("read_no_write", {24'd0, regs[0]}, 32'hFF);
      check("read_frame", {16'd0, rx_q[$]}, 32'h0000);

      // req1 raised and withdrawn while a req0 frame is on the wire.
      base = acc_q.size();
      nrx = rx_q.size();
      send(1'b0, 1'b1, REG_EN_PWM_7_0, 8'h0F);
      wait_cycles(19);
      bus.req1_valid = 1'b1;
      wait_cycles(80);
      bus.req1_valid = 1'b0;
      wait_cycles(PERIOD);
      check("withdraw_accepts", acc_q.size() - base, 32'd1);
      check("withdraw_frames", rx_q.size() - nrx, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_cfg_sequencer.md
Name: spi_cfg_sequencer

Overview:
- On-chip SPI controller that shares one SPI link between two register-write requesters.
- Arbitrates round-robin between them and serializes each accepted request into a 16-bit frame on nCS/SCLK/COPI: {wr, addr[6:0], data[7:0]}, MSB first, SPI mode 0.
- Drives the SPI configuration peripheral that owns the output-enable, PWM-enable and duty-cycle registers.
- Paces frames so the peripheral's 2-flop synchronizers and commit logic always complete between frames.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period. Must be >= 2; elaboration error otherwise.
- CS_SETUP, 2: clk cycles nCS is low before the first SCLK rise, in addition to the first bit's low phase. Must be >= 1.
- CS_IDLE, 4: minimum clk cycles nCS is high between frames. Must be >= 4.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a frame pending.
- req0_wr  in  1  frame bit 15 (1 = write).
- req0_addr  in  7  register address.
- req0_data  in  8  register data.
- req0_ready  out  1  requester 0 accepted this cycle when valid && ready.
- req1_valid, req1_wr, req1_addr, req1_data, req1_ready: same as requester 0.
- nCS  out  1  SPI chip select, active low.
- SCLK  out  1  SPI clock, idles low.
- COPI  out  1  SPI data out.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  requester owning the current or most recent frame.
- frame_done  out  1  1-cycle pulse on the cycle nCS returns high after a complete frame.

Behaviour:
- Reset values (registered): nCS=1, SCLK=0, COPI=0, busy=0, grant_id=0, frame_done=0. Round-robin pointer set so requester 0 wins the first tie. State=IDLE.
- Reset mid-frame: the next cycle shows the reset values. The frame is aborted, with no frame_done and no acceptance.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - reqX_ready is combinational: asserted only in IDLE, and only for the arbiter winner.
  - On acceptance, latch {wr,addr,data} into the 16-bit shift register, set grant_id, go to SETUP, and drive nCS=0 on the next cycle.
- SETUP: lasts CS_SETUP cycles; COPI = frame bit 15.
- SHIFT: 16 bits, each 2*CLK_DIV cycles.
  - SCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - COPI changes only at the start of a bit's low phase and is stable across the rising edge.
  - After the 16th high phase, SCLK returns low and the state goes to HOLD.
- HOLD: CLK_DIV cycles with SCLK=0 and nCS=0.
- GAP:
  - Entry cycle: nCS=1, frame_done=1, COPI=0.
  - Lasts CS_IDLE cycles, then returns to IDLE.
- Latency at defaults, with acceptance at cycle T:
  - nCS falls at T+1.
  - First SCLK rise at T+7; the 16th rise at T+127.
  - nCS rises and frame_done fires at T+135.
  - Next acceptance is possible at T+139, giving a 139-cycle frame period.
  - General period: 1 + CS_SETUP + 32*CLK_DIV + CLK_DIV + CS_IDLE.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the one not served last wins, and the pointer updates on acceptance only.
  - Valid may be withdrawn before acceptance with no side effect. Payload is sampled only on the acceptance cycle.
- Frames with wr=0 are serialized identically; the peripheral ignores them.
- Bit counter is 5 bits and phase counter is ceil(log2(CLK_DIV)) bits. There is no wrap beyond 16 bits: SHIFT exits on count 16.

Decomposition:
- Package spi_cfg_pkg holds:
  - FRAME_W=16, ADDR_W=7, DATA_W=8.
  - Register address constants: REG_EN_OUT_7_0=0x00, REG_EN_OUT_15_8=0x01, REG_EN_PWM_7_0=0x02, REG_EN_PWM_15_8=0x03, REG_PWM_DUTY=0x04.
  - Sequencer state enum.
- One sub-module, rr_arbiter2: 2-way round-robin grant with a pointer updated on accept.
- SPI timing and FSM stay in the top module.

Test Plan:
- Single request, req0 wr=1 addr=0x02 data=0xA5 -> COPI sampled at the 16 SCLK rises = 0x82A5. nCS low T+1..T+134; frame_done only at T+135; req0_ready high only at T.
- req0 and req1 both held valid continuously from reset -> grant order 0,1,0,1. Accepts 139 cycles apart; no SCLK activity while nCS=1.
- Only req1 valid for 3 back-to-back frames -> three consecutive grants to req1, each with grant_id=1, each with exactly 16 SCLK rises.
- rst=1 for one cycle 40 cycles after acceptance:
  - Next cycle nCS=1, SCLK=0, COPI=0, busy=0, with no frame_done.
  - A subsequent request produces a full correct frame.
- Connected to the SPI configuration peripheral (same clk):
  - Write 0x04/0x80 -> pwm_duty_cycle=0x80.
  - Write 0x00/0xFF -> en_reg_out_7_0=0xFF.
  - wr=0 frame to 0x00 -> en_reg_out_7_0 stays 0xFF.
- req1_valid raised during a req0 frame and dropped before IDLE -> no req1 acceptance and no extra frame.
